// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the registered ALU control decoder: ALUOp classes,
// R-type Funct values, ALU operation codes and the sequencer state type.
package alu_ctrl_pkg;

  localparam int unsigned OP_BITS = 4;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned CODE_W  = 5;

  localparam logic [OP_BITS-1:0] OP_RTYPE = 4'b0000;
  localparam logic [OP_BITS-1:0] OP_MUL   = 4'b0001;
  localparam logic [OP_BITS-1:0] OP_SEX   = 4'b0010;
  localparam logic [OP_BITS-1:0] OP_ANDI  = 4'b0011;
  localparam logic [OP_BITS-1:0] OP_ORI   = 4'b0100;
  localparam logic [OP_BITS-1:0] OP_XORI  = 4'b0101;
  localparam logic [OP_BITS-1:0] OP_ADDI  = 4'b0110;
  localparam logic [OP_BITS-1:0] OP_ADDIU = 4'b0111;
  localparam logic [OP_BITS-1:0] OP_SLTI  = 4'b1000;
  localparam logic [OP_BITS-1:0] OP_SLTIU = 4'b1001;
  localparam logic [OP_BITS-1:0] OP_LUI   = 4'b1010;
  localparam logic [OP_BITS-1:0] OP_BGEZ  = 4'b1011;
  localparam logic [OP_BITS-1:0] OP_BLEZ  = 4'b1100;
  localparam logic [OP_BITS-1:0] OP_BZ    = 4'b1101;

  localparam logic [FUNCT_W-1:0] F_ADD  = 6'b100000;
  localparam logic [FUNCT_W-1:0] F_ADDU = 6'b100001;
  localparam logic [FUNCT_W-1:0] F_SUB  = 6'b100010;
  localparam logic [FUNCT_W-1:0] F_AND  = 6'b100100;
  localparam logic [FUNCT_W-1:0] F_OR   = 6'b100101;
  localparam logic [FUNCT_W-1:0] F_NOR  = 6'b100111;
  localparam logic [FUNCT_W-1:0] F_XOR  = 6'b100110;
  localparam logic [FUNCT_W-1:0] F_SLT  = 6'b101010;
  localparam logic [FUNCT_W-1:0] F_SLTU = 6'b101011;
  localparam logic [FUNCT_W-1:0] F_SLL  = 6'b000000;
  localparam logic [FUNCT_W-1:0] F_SLLV = 6'b000100;
  localparam logic [FUNCT_W-1:0] F_SRL  = 6'b000010;
  localparam logic [FUNCT_W-1:0] F_SRLV = 6'b000110;
  localparam logic [FUNCT_W-1:0] F_SRA  = 6'b000011;
  localparam logic [FUNCT_W-1:0] F_SRAV = 6'b000111;
  localparam logic [FUNCT_W-1:0] F_MOVN = 6'b001011;
  localparam logic [FUNCT_W-1:0] F_MOVZ = 6'b001010;
  localparam logic [FUNCT_W-1:0] F_JR   = 6'b001000;

  localparam logic [CODE_W-1:0] ALU_AND  = 5'b00000;
  localparam logic [CODE_W-1:0] ALU_OR   = 5'b00001;
  localparam logic [CODE_W-1:0] ALU_ADD  = 5'b00010;
  localparam logic [CODE_W-1:0] ALU_MUL  = 5'b00011;
  localparam logic [CODE_W-1:0] ALU_NOR  = 5'b00100;
  localparam logic [CODE_W-1:0] ALU_XOR  = 5'b00101;
  localparam logic [CODE_W-1:0] ALU_SUB  = 5'b00110;
  localparam logic [CODE_W-1:0] ALU_SLT  = 5'b00111;
  localparam logic [CODE_W-1:0] ALU_SLL  = 5'b01000;
  localparam logic [CODE_W-1:0] ALU_MOVN = 5'b01010;
  localparam logic [CODE_W-1:0] ALU_MOVZ = 5'b01011;
  localparam logic [CODE_W-1:0] ALU_SRL  = 5'b01101;
  localparam logic [CODE_W-1:0] ALU_ROTR = 5'b01110;
  localparam logic [CODE_W-1:0] ALU_SRA  = 5'b01111;
  localparam logic [CODE_W-1:0] ALU_BGEZ = 5'b10001;
  localparam logic [CODE_W-1:0] ALU_LUI  = 5'b10011;
  localparam logic [CODE_W-1:0] ALU_SEB  = 5'b10100;
  localparam logic [CODE_W-1:0] ALU_SEH  = 5'b10101;
  localparam logic [CODE_W-1:0] ALU_BLEZ = 5'b11001;

  typedef enum logic {IDLE = 1'b0, MUL = 1'b1} state_t;

  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic              sa;
    logic              uns;
    logic              jr;
    logic              is_mul;
  } dec_t;

endpackage

// File: rtl/alu_ctrl_dec.sv
// Purely combinational ALUOp/Funct decode into an ALU operation code plus
// shift-source, unsigned, jr and multi-cycle flags.
module alu_ctrl_dec
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned OP_W = 4
) (
  input  logic [OP_W-1:0]    alu_op_i,
  input  logic [FUNCT_W-1:0] funct_i,
  input  logic               i_twenty_one_i,
  input  logic               i_six_i,
  input  logic               i_nine_i,
  output dec_t               dec_o
);

  always_comb begin
    dec_o = '0;
    case (alu_op_i)
      OP_W'(OP_RTYPE): begin
        case (funct_i)
          F_ADD, F_ADDU: dec_o.code = ALU_ADD;
          F_SUB:         dec_o.code = ALU_SUB;
          F_AND:         dec_o.code = ALU_AND;
          F_OR:          dec_o.code = ALU_OR;
          F_NOR:         dec_o.code = ALU_NOR;
          F_XOR:         dec_o.code = ALU_XOR;
          F_SLT, F_SLTU: dec_o.code = ALU_SLT;
          F_SLL: begin
            dec_o.code = ALU_SLL;
            dec_o.sa   = 1'b1;
          end
          F_SLLV:        dec_o.code = ALU_SLL;
          // srl/rotr and srlv/rotrv share a Funct; one instruction bit picks
          F_SRL: begin
            dec_o.code = i_twenty_one_i ? ALU_ROTR : ALU_SRL;
            dec_o.sa   = 1'b1;
          end
          F_SRLV:        dec_o.code = i_six_i ? ALU_ROTR : ALU_SRL;
          F_SRA: begin
            dec_o.code = ALU_SRA;
            dec_o.sa   = 1'b1;
          end
          F_SRAV:        dec_o.code = ALU_SRA;
          F_MOVN:        dec_o.code = ALU_MOVN;
          F_MOVZ:        dec_o.code = ALU_MOVZ;
          F_JR: begin
            dec_o.code = ALU_AND;
            dec_o.jr   = 1'b1;
          end
          default:       dec_o.code = ALU_AND;
        endcase
      end
      OP_W'(OP_MUL): begin
        dec_o.code   = ALU_MUL;
        dec_o.is_mul = 1'b1;
      end
      OP_W'(OP_SEX):   dec_o.code = i_nine_i ? ALU_SEH : ALU_SEB;
      OP_W'(OP_ANDI):  dec_o.code = ALU_AND;
      OP_W'(OP_ORI):   dec_o.code = ALU_OR;
      OP_W'(OP_XORI):  dec_o.code = ALU_XOR;
      OP_W'(OP_ADDI):  dec_o.code = ALU_ADD;
      OP_W'(OP_ADDIU): begin
        dec_o.code = ALU_ADD;
        dec_o.uns  = 1'b1;
      end
      OP_W'(OP_SLTI), OP_W'(OP_SLTIU): dec_o.code = ALU_SLT;
      OP_W'(OP_LUI):   dec_o.code = ALU_LUI;
      OP_W'(OP_BGEZ):  dec_o.code = ALU_BGEZ;
      OP_W'(OP_BLEZ):  dec_o.code = ALU_BLEZ;
      OP_W'(OP_BZ):    dec_o.code = ALU_SUB;
      default:         dec_o.code = ALU_AND;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Registered ALU control stage: one decode per handshake, with multiply ops
// occupying MUL_LAT cycles and stalling the upstream stages meanwhile.
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned OP_W    = 4,
  parameter int unsigned SIG_W   = 5,
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned CNT_W   = $clog2(MUL_LAT + 1)
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             InValid,
  output logic             InReady,
  input  logic [OP_W-1:0]  ALUOp,
  input  logic [5:0]       Funct,
  input  logic             ITwentyOne,
  input  logic             ISix,
  input  logic             Inine,
  output logic             OutValid,
  output logic [SIG_W-1:0] ALUSignal,
  output logic             SAControl,
  output logic             UnsignedSignal,
  output logic             ALU_C,
  output logic             Stall
);

  dec_t dec;

  alu_ctrl_dec #(.OP_W(OP_W)) u_dec (
    .alu_op_i       (ALUOp),
    .funct_i        (Funct),
    .i_twenty_one_i (ITwentyOne),
    .i_six_i        (ISix),
    .i_nine_i       (Inine),
    .dec_o          (dec)
  );

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SIG_W-1:0]   sig_q, sig_d;
  logic               sa_q, sa_d;
  logic               uns_q, uns_d;
  logic               jr_q, jr_d;
  logic               valid_q, valid_d;
  logic               stall_q, stall_d;
  logic               ready_q, ready_d;

  // Next-state: accept only in IDLE; MUL counts down to the completing cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sig_d   = sig_q;
    sa_d    = sa_q;
    uns_d   = uns_q;
    jr_d    = jr_q;
    valid_d = 1'b0;
    stall_d = stall_q;
    ready_d = ready_q;
    case (state_q)
      IDLE: begin
        if (InValid) begin
          sig_d = SIG_W'(dec.code);
          sa_d  = dec.sa;
          uns_d = dec.uns;
          jr_d  = dec.jr;
          if (dec.is_mul && (MUL_LAT > 1)) begin
            state_d = MUL;
            cnt_d   = CNT_W'(MUL_LAT - 1);
            stall_d = 1'b1;
            ready_d = 1'b0;
          end else begin
            valid_d = 1'b1;
          end
        end
      end
      MUL: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          stall_d = 1'b0;
          ready_d = 1'b1;
          valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sig_q   <= '0;
      sa_q    <= 1'b0;
      uns_q   <= 1'b0;
      jr_q    <= 1'b0;
      valid_q <= 1'b0;
      stall_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sig_q   <= sig_d;
      sa_q    <= sa_d;
      uns_q   <= uns_d;
      jr_q    <= jr_d;
      valid_q <= valid_d;
      stall_q <= stall_d;
      ready_q <= ready_d;
    end
  end

  assign InReady        = ready_q;
  assign OutValid       = valid_q;
  assign ALUSignal      = sig_q;
  assign SAControl      = sa_q;
  assign UnsignedSignal = uns_q;
  assign ALU_C          = jr_q;
  assign Stall          = stall_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Bench for alu_ctrl_seq: MUL_LAT=4 and MUL_LAT=1 instances share stimulus;
// per-instance scoreboards compare every OutValid pulse against expectations.
module tb_alu_ctrl_seq;

  typedef struct packed {
    logic [4:0] sig;
    logic       sa;
    logic       uns;
    logic       jr;
  } exp_t;

  typedef struct {
    logic [3:0] op;
    logic [5:0] funct;
    logic       i21;
    logic       i6;
    logic       i9;
    exp_t       e;
  } vec_t;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic       InValid;
  logic [3:0] ALUOp;
  logic [5:0] Funct;
  logic       ITwentyOne, ISix, Inine;

  logic       a_InReady, a_OutValid, a_SAControl, a_UnsignedSignal, a_ALU_C, a_Stall;
  logic [4:0] a_ALUSignal;
  logic       b_InReady, b_OutValid, b_SAControl, b_UnsignedSignal, b_ALU_C, b_Stall;
  logic [4:0] b_ALUSignal;

  int checks = 0;
  int errors = 0;

  exp_t q4[$];
  exp_t q1[$];
  exp_t e4, e1;
  vec_t tbl[$];

  always #5 Clk = ~Clk;

  alu_ctrl_seq #(.OP_W(4), .SIG_W(5), .MUL_LAT(4)) u_l4 (
    .Clk(Clk), .Rst_n(Rst_n), .InValid(InValid), .InReady(a_InReady),
    .ALUOp(ALUOp), .Funct(Funct), .ITwentyOne(ITwentyOne), .ISix(ISix),
    .Inine(Inine), .OutValid(a_OutValid), .ALUSignal(a_ALUSignal),
    .SAControl(a_SAControl), .UnsignedSignal(a_UnsignedSignal),
    .ALU_C(a_ALU_C), .Stall(a_Stall)
  );

  alu_ctrl_seq #(.OP_W(4), .SIG_W(5), .MUL_LAT(1)) u_l1 (
    .Clk(Clk), .Rst_n(Rst_n), .InValid(InValid), .InReady(b_InReady),
    .ALUOp(ALUOp), .Funct(Funct), .ITwentyOne(ITwentyOne), .ISix(ISix),
    .Inine(Inine), .OutValid(b_OutValid), .ALUSignal(b_ALUSignal),
    .SAControl(b_SAControl), .UnsignedSignal(b_UnsignedSignal),
    .ALU_C(b_ALU_C), .Stall(b_Stall)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [4:0] sig, input logic sa, input logic uns, input logic jr);
    exp_t e;
    e.sig = sig; e.sa = sa; e.uns = uns; e.jr = jr;
    return e;
  endfunction

  task automatic add(input logic [3:0] op, input logic [5:0] f, input logic i21,
                     input logic i6, input logic i9, input exp_t e);
    vec_t v;
    v.op = op; v.funct = f; v.i21 = i21; v.i6 = i6; v.i9 = i9; v.e = e;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [5:0] f,
                       input logic i21, input logic i6, input logic i9);
    InValid = v; ALUOp = op; Funct = f; ITwentyOne = i21; ISix = i6; Inine = i9;
  endtask

  task automatic step();
    @(posedge Clk);
    #2;
  endtask

  // Scoreboards: every OutValid pulse must match the oldest outstanding expectation
  always @(negedge Clk) begin
    if (Rst_n === 1'b1 && a_OutValid === 1'b1) begin
      if (q4.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_l4 unexpected OutValid got=%h", a_ALUSignal);
      end else begin
        e4 = q4.pop_front();
        chk("sb_l4", 32'({a_ALUSignal, a_SAControl, a_UnsignedSignal, a_ALU_C}), 32'(e4));
      end
    end
  end

  always @(negedge Clk) begin
    if (Rst_n === 1'b1 && b_OutValid === 1'b1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_l1 unexpected OutValid got=%h", b_ALUSignal);
      end else begin
        e1 = q1.pop_front();
        chk("sb_l1", 32'({b_ALUSignal, b_SAControl, b_UnsignedSignal, b_ALU_C}), 32'(e1));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t em, eo;
    add(4'h0, 6'b100010, 0, 0, 0, mk(5'b00110, 0, 0, 0));
    add(4'h0, 6'b000010, 1, 0, 0, mk(5'b01110, 1, 0, 0));
    add(4'h0, 6'b000110, 0, 0, 0, mk(5'b01101, 0, 0, 0));
    add(4'h0, 6'b100000, 1, 1, 1, mk(5'b00010, 0, 0, 0));
    add(4'h0, 6'b100001, 0, 0, 0, mk(5'b00010, 0, 0, 0));
    add(4'h0, 6'b100100, 0, 0, 0, mk(5'b00000, 0, 0, 0));
    add(4'h0, 6'b100101, 0, 0, 0, mk(5'b00001, 0, 0, 0));
    add(4'h0, 6'b100111, 0, 0, 0, mk(5'b00100, 0, 0, 0));
    add(4'h0, 6'b100110, 0, 0, 0, mk(5'b00101, 0, 0, 0));
    add(4'h0, 6'b101010, 0, 0, 0, mk(5'b00111, 0, 0, 0));
    add(4'h0, 6'b101011, 0, 0, 0, mk(5'b00111, 0, 0, 0));
    add(4'h0, 6'b000000, 0, 0, 0, mk(5'b01000, 1, 0, 0));
    add(4'h0, 6'b000100, 0, 0, 0, mk(5'b01000, 0, 0, 0));
    add(4'h0, 6'b000010, 0, 1, 0, mk(5'b01101, 1, 0, 0));
    add(4'h0, 6'b000110, 1, 1, 0, mk(5'b01110, 0, 0, 0));
    add(4'h0, 6'b000011, 0, 0, 0, mk(5'b01111, 1, 0, 0));
    add(4'h0, 6'b000111, 0, 0, 0, mk(5'b01111, 0, 0, 0));
    add(4'h0, 6'b001011, 0, 0, 0, mk(5'b01010, 0, 0, 0));
    add(4'h0, 6'b001010, 0, 0, 0, mk(5'b01011, 0, 0, 0));
    add(4'h0, 6'b000001, 1, 1, 1, mk(5'b00000, 0, 0, 0));
    add(4'h2, 6'b000000, 0, 0, 1, mk(5'b10101, 0, 0, 0));
    add(4'h2, 6'b000000, 0, 0, 0, mk(5'b10100, 0, 0, 0));
    add(4'h3, 6'b100000, 0, 0, 0, mk(5'b00000, 0, 0, 0));
    add(4'h4, 6'b000000, 0, 0, 0, mk(5'b00001, 0, 0, 0));
    add(4'h5, 6'b000000, 0, 0, 0, mk(5'b00101, 0, 0, 0));
    add(4'h6, 6'b000000, 0, 0, 0, mk(5'b00010, 0, 0, 0));
    add(4'h7, 6'b000000, 0, 0, 0, mk(5'b00010, 0, 1, 0));
    add(4'h8, 6'b000000, 0, 0, 0, mk(5'b00111, 0, 0, 0));
    add(4'h9, 6'b000000, 0, 0, 0, mk(5'b00111, 0, 0, 0));
    add(4'hA, 6'b000000, 0, 0, 0, mk(5'b10011, 0, 0, 0));
    add(4'hB, 6'b000000, 0, 0, 0, mk(5'b10001, 0, 0, 0));
    add(4'hC, 6'b000000, 0, 0, 0, mk(5'b11001, 0, 0, 0));
    add(4'hD, 6'b000000, 0, 0, 0, mk(5'b00110, 0, 0, 0));
    add(4'hE, 6'b000000, 0, 0, 0, mk(5'b00000, 0, 0, 0));
    add(4'hF, 6'b000000, 0, 0, 0, mk(5'b00000, 0, 0, 0));
    add(4'h0, 6'b001000, 0, 0, 0, mk(5'b00000, 0, 0, 1));

    Rst_n = 1'b0;
    drive(0, 4'h0, 6'h00, 0, 0, 0);
    step();
    step();
    chk("rst_sig", 32'(a_ALUSignal), 32'd0);
    chk("rst_flags", 32'({a_SAControl, a_UnsignedSignal, a_ALU_C}), 32'd0);
    chk("rst_valid", 32'(a_OutValid), 32'd0);
    chk("rst_stall", 32'(a_Stall), 32'd0);
    chk("rst_ready", 32'(a_InReady), 32'd1);
    @(negedge Clk);
    Rst_n = 1'b1;
    step();

    // Back-to-back single-cycle decodes: OutValid must stay high throughout
    for (int i = 0; i < tbl.size(); i++) begin
      drive(1, tbl[i].op, tbl[i].funct, tbl[i].i21, tbl[i].i6, tbl[i].i9);
      q4.push_back(tbl[i].e);
      q1.push_back(tbl[i].e);
      step();
      chk("b2b_valid_l4", 32'(a_OutValid), 32'd1);
      chk("b2b_stall_l4", 32'(a_Stall), 32'd0);
      chk("b2b_valid_l1", 32'(b_OutValid), 32'd1);
    end
    drive(0, 4'h0, 6'h00, 0, 0, 0);
    step();
    chk("pulse_end_l4", 32'(a_OutValid), 32'd0);
    chk("jr_held_l4", 32'(a_ALU_C), 32'd1);

    // Multiply: MUL_LAT=4 stalls three cycles, MUL_LAT=1 completes at once
    em = mk(5'b00011, 0, 0, 0);
    eo = mk(5'b00001, 0, 0, 0);
    drive(1, 4'h1, 6'h00, 0, 0, 0);
    q4.push_back(em);
    q1.push_back(em);
    step();
    chk("mul_stall_l4", 32'(a_Stall), 32'd1);
    chk("mul_ready_l4", 32'(a_InReady), 32'd0);
    chk("mul_valid_l4", 32'(a_OutValid), 32'd0);
    chk("mul_sig_l4", 32'(a_ALUSignal), 32'b00011);
    chk("mul_stall_l1", 32'(b_Stall), 32'd0);
    chk("mul_valid_l1", 32'(b_OutValid), 32'd1);
    chk("mul_sig_l1", 32'(b_ALUSignal), 32'b00011);
    drive(1, 4'h4, 6'h00, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      q1.push_back(eo);
      step();
      chk("mul_sig_hold_l4", 32'(a_ALUSignal), 32'b00011);
      if (i < 2) begin
        chk("mul_stall_n_l4", 32'(a_Stall), 32'd1);
        chk("mul_novalid_l4", 32'(a_OutValid), 32'd0);
      end else begin
        chk("mul_done_stall_l4", 32'(a_Stall), 32'd0);
        chk("mul_done_valid_l4", 32'(a_OutValid), 32'd1);
        chk("mul_done_ready_l4", 32'(a_InReady), 32'd1);
      end
    end
    q1.push_back(eo);
    q4.push_back(eo);
    step();
    chk("post_mul_valid_l4", 32'(a_OutValid), 32'd1);
    chk("post_mul_sig_l4", 32'(a_ALUSignal), 32'b00001);
    drive(0, 4'h0, 6'h00, 0, 0, 0);
    step();

    // Reset in the second multiply cycle aborts it with no OutValid
    drive(1, 4'h1, 6'h00, 0, 0, 0);
    q4.push_back(em);
    q1.push_back(em);
    step();
    chk("abort_stall_pre", 32'(a_Stall), 32'd1);
    drive(0, 4'h0, 6'h00, 0, 0, 0);
    step();
    Rst_n = 1'b0;
    q4.delete();
    q1.delete();
    #1;
    chk("abort_stall", 32'(a_Stall), 32'd0);
    chk("abort_sig", 32'(a_ALUSignal), 32'd0);
    chk("abort_ready", 32'(a_InReady), 32'd1);
    chk("abort_valid", 32'(a_OutValid), 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("abort_no_valid", 32'(a_OutValid), 32'd0);
      chk("abort_no_stall", 32'(a_Stall), 32'd0);
    end

    chk("sb_l4_drained", 32'(q4.size()), 32'd0);
    chk("sb_l1_drained", 32'(q1.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
